// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble/flush insertion.
// Optional HAZARD_PERF_CNT_EN adds saturating bubble_cnt/flush_cnt performance counters.
module id_ex_stage_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_memtoreg,
  input  logic            id_alusrc,
  input  logic            id_branch,
  input  logic [1:0]      id_aluop,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic            ex_flush,
  input  logic            ext_stall,
  output logic            idex_valid,
  output logic [XLEN-1:0] idex_pc,
  output logic [4:0]      idex_rs1,
  output logic [4:0]      idex_rs2,
  output logic [4:0]      idex_rd,
  output logic            idex_uses_rs1,
  output logic            idex_uses_rs2,
  output logic [XLEN-1:0] idex_rs1_data,
  output logic [XLEN-1:0] idex_rs2_data,
  output logic [XLEN-1:0] idex_imm,
  output logic            idex_regwrite,
  output logic            idex_memread,
  output logic            idex_memwrite,
  output logic            idex_memtoreg,
  output logic            idex_alusrc,
  output logic            idex_branch,
  output logic [1:0]      idex_aluop,
  output logic [2:0]      idex_funct3,
  output logic            idex_funct7b5,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic            load_use_stall,
  output logic [31:0]     bubble_cnt,
  output logic [31:0]     flush_cnt
`else
  output logic            load_use_stall
`endif
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            alusrc;
    logic            branch;
    logic [1:0]      aluop;
    logic [2:0]      funct3;
    logic            funct7b5;
  } stage_t;

  stage_t id_b;
  stage_t q;
  logic   lu;
  logic   bubble;

  assign id_b = '{
    valid:    id_valid,
    pc:       id_pc,
    rs1:      id_rs1,
    rs2:      id_rs2,
    rd:       id_rd,
    uses_rs1: id_uses_rs1,
    uses_rs2: id_uses_rs2,
    rs1_data: id_rs1_data,
    rs2_data: id_rs2_data,
    imm:      id_imm,
    regwrite: id_regwrite,
    memread:  id_memread,
    memwrite: id_memwrite,
    memtoreg: id_memtoreg,
    alusrc:   id_alusrc,
    branch:   id_branch,
    aluop:    id_aluop,
    funct3:   id_funct3,
    funct7b5: id_funct7b5
  };

  // A load in EX whose destination is read by a real ID instruction; x0 never hazards.
  assign lu = q.valid && q.memread && (q.rd != 5'd0) && id_valid &&
              ((id_uses_rs1 && (id_rs1 == q.rd)) || (id_uses_rs2 && (id_rs2 == q.rd)));

  assign load_use_stall = lu && !ex_flush && !ext_stall;
  assign pc_write       = !(ext_stall || load_use_stall);
  assign ifid_write     = pc_write;
  assign ifid_flush     = ex_flush && !ext_stall;
  assign bubble         = ex_flush || load_use_stall;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (!ext_stall) begin
      // An all-zero bubble has rd=0, so forwarding can never match it.
      q <= bubble ? '0 : id_b;
    end
  end

  assign idex_valid    = q.valid;
  assign idex_pc       = q.pc;
  assign idex_rs1      = q.rs1;
  assign idex_rs2      = q.rs2;
  assign idex_rd       = q.rd;
  assign idex_uses_rs1 = q.uses_rs1;
  assign idex_uses_rs2 = q.uses_rs2;
  assign idex_rs1_data = q.rs1_data;
  assign idex_rs2_data = q.rs2_data;
  assign idex_imm      = q.imm;
  assign idex_regwrite = q.regwrite;
  assign idex_memread  = q.memread;
  assign idex_memwrite = q.memwrite;
  assign idex_memtoreg = q.memtoreg;
  assign idex_alusrc   = q.alusrc;
  assign idex_branch   = q.branch;
  assign idex_aluop    = q.aluop;
  assign idex_funct3   = q.funct3;
  assign idex_funct7b5 = q.funct7b5;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (!ext_stall) begin
      if (load_use_stall && (bubble_cnt != 32'hFFFF_FFFF)) bubble_cnt <= bubble_cnt + 32'd1;
      if (ifid_flush && (flush_cnt != 32'hFFFF_FFFF))      flush_cnt  <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed hazard/flush/freeze/reset steps plus
// randomized traffic checked against a behavioural pipeline-register model.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        uses_rs1;
    logic        uses_rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic        branch;
    logic [1:0]  aluop;
    logic [2:0]  funct3;
    logic        funct7b5;
  } bundle_t;

  logic    clk = 1'b0;
  logic    rst_n = 1'b1;
  logic    ex_flush = 1'b0;
  logic    ext_stall = 1'b0;
  bundle_t id = '0;
  bundle_t dut_q;
  bundle_t model_q = '0;

  logic        idex_valid, idex_uses_rs1, idex_uses_rs2;
  logic [31:0] idex_pc, idex_rs1_data, idex_rs2_data, idex_imm;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;
  logic        idex_regwrite, idex_memread, idex_memwrite, idex_memtoreg, idex_alusrc, idex_branch;
  logic [1:0]  idex_aluop;
  logic [2:0]  idex_funct3;
  logic        idex_funct7b5;
  logic        pc_write, ifid_write, ifid_flush, load_use_stall;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] bubble_cnt, flush_cnt;
  logic [31:0] m_bubbles = '0;
  logic [31:0] m_flushes = '0;
`endif

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id.valid), .id_pc(id.pc), .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
    .id_uses_rs1(id.uses_rs1), .id_uses_rs2(id.uses_rs2),
    .id_rs1_data(id.rs1_data), .id_rs2_data(id.rs2_data), .id_imm(id.imm),
    .id_regwrite(id.regwrite), .id_memread(id.memread), .id_memwrite(id.memwrite),
    .id_memtoreg(id.memtoreg), .id_alusrc(id.alusrc), .id_branch(id.branch),
    .id_aluop(id.aluop), .id_funct3(id.funct3), .id_funct7b5(id.funct7b5),
    .ex_flush(ex_flush), .ext_stall(ext_stall),
    .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
    .idex_rd(idex_rd), .idex_uses_rs1(idex_uses_rs1), .idex_uses_rs2(idex_uses_rs2),
    .idex_rs1_data(idex_rs1_data), .idex_rs2_data(idex_rs2_data), .idex_imm(idex_imm),
    .idex_regwrite(idex_regwrite), .idex_memread(idex_memread), .idex_memwrite(idex_memwrite),
    .idex_memtoreg(idex_memtoreg), .idex_alusrc(idex_alusrc), .idex_branch(idex_branch),
    .idex_aluop(idex_aluop), .idex_funct3(idex_funct3), .idex_funct7b5(idex_funct7b5),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
`ifdef HAZARD_PERF_CNT_EN
    .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`else
    .load_use_stall(load_use_stall)
`endif
  );

  always_comb begin
    dut_q = '{
      valid: idex_valid, pc: idex_pc, rs1: idex_rs1, rs2: idex_rs2, rd: idex_rd,
      uses_rs1: idex_uses_rs1, uses_rs2: idex_uses_rs2,
      rs1_data: idex_rs1_data, rs2_data: idex_rs2_data, imm: idex_imm,
      regwrite: idex_regwrite, memread: idex_memread, memwrite: idex_memwrite,
      memtoreg: idex_memtoreg, alusrc: idex_alusrc, branch: idex_branch,
      aluop: idex_aluop, funct3: idex_funct3, funct7b5: idex_funct7b5
    };
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Small register indices (0..3) make dependences between neighbours frequent.
  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.valid    = ($urandom_range(0, 7) != 0);
    b.pc       = $urandom;
    b.rs1      = 5'($urandom_range(0, 3));
    b.rs2      = 5'($urandom_range(0, 3));
    b.rd       = 5'($urandom_range(0, 3));
    b.uses_rs1 = 1'($urandom);
    b.uses_rs2 = 1'($urandom);
    b.rs1_data = $urandom;
    b.rs2_data = $urandom;
    b.imm      = $urandom;
    b.regwrite = 1'($urandom);
    b.memread  = 1'($urandom);
    b.memwrite = 1'($urandom);
    b.memtoreg = 1'($urandom);
    b.alusrc   = 1'($urandom);
    b.branch   = 1'($urandom);
    b.aluop    = 2'($urandom);
    b.funct3   = 3'($urandom);
    b.funct7b5 = 1'($urandom);
    return b;
  endfunction

  function automatic bundle_t instr(input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [4:0] rd, input logic u1, input logic u2,
                                    input logic memread);
    bundle_t b = rand_bundle();
    b.valid = 1'b1; b.rs1 = rs1; b.rs2 = rs2; b.rd = rd;
    b.uses_rs1 = u1; b.uses_rs2 = u2; b.memread = memread;
    return b;
  endfunction

  // Reference rule: does the instruction waiting in ID read the register a pending load in EX writes?
  function automatic logic hazard(input bundle_t ex, input bundle_t dec);
    if (!(ex.valid && ex.memread && dec.valid) || ex.rd == 5'd0) return 1'b0;
    return (dec.uses_rs1 && dec.rs1 == ex.rd) || (dec.uses_rs2 && dec.rs2 == ex.rd);
  endfunction

  task automatic apply(input bundle_t b, input logic fl, input logic st);
    id = b; ex_flush = fl; ext_stall = st;
  endtask

  task automatic model_reset();
    model_q = '0;
`ifdef HAZARD_PERF_CNT_EN
    m_bubbles = '0; m_flushes = '0;
`endif
  endtask

  // Called just after a negedge with inputs driven; checks comb outputs, clocks, checks state.
  task automatic cycle();
    logic stall;
    logic frozen;
    #1;
    frozen = ext_stall;
    stall  = hazard(model_q, id) && !ex_flush && !frozen;
    check("comb", 160'({pc_write, ifid_write, ifid_flush, load_use_stall}),
          160'({!(frozen || stall), !(frozen || stall), ex_flush && !frozen, stall}));
    @(posedge clk);
    if (!frozen) begin
`ifdef HAZARD_PERF_CNT_EN
      if (stall && m_bubbles != 32'hFFFF_FFFF) m_bubbles++;
      if (ex_flush && m_flushes != 32'hFFFF_FFFF) m_flushes++;
`endif
      model_q = (ex_flush || stall) ? bundle_t'('0) : id;
    end
    #1;
    check("idex", 160'(dut_q), 160'(model_q));
`ifdef HAZARD_PERF_CNT_EN
    check("bubble_cnt", 160'(bubble_cnt), 160'(m_bubbles));
    check("flush_cnt", 160'(flush_cnt), 160'(m_flushes));
`endif
    @(negedge clk);
  endtask

  initial begin
    bundle_t lw, add;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("reset_idex", 160'(dut_q), 160'(0));
    check("reset_comb", 160'({pc_write, ifid_write, ifid_flush, load_use_stall}), 160'(4'b1100));
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use: lw x5 then add x6,x5,x7 costs exactly one bubble
    lw  = instr(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
    add = instr(5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0);
    apply(lw, 1'b0, 1'b0);  cycle();
    apply(add, 1'b0, 1'b0);
    #1;
    check("lu_stall", 160'({load_use_stall, pc_write, ifid_write}), 160'(3'b100));
    cycle();
    check("lu_bubble", 160'({idex_valid, idex_rd}), 160'(0));
    cycle();
    check("lu_add_loaded", 160'({idex_valid, idex_rs1}), 160'({1'b1, 5'd5}));

    // No false stall: lui ignores its rs1 field; a load to x0 never stalls
    apply(lw, 1'b0, 1'b0);  cycle();
    apply(instr(5'd5, 5'd5, 5'd6, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);
    #1;
    check("lui_no_stall", 160'(load_use_stall), 160'(0));
    cycle();
    check("lui_loaded", 160'({idex_valid, idex_rd}), 160'({1'b1, 5'd6}));
    apply(instr(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1), 1'b0, 1'b0);  cycle();
    apply(instr(5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
    #1;
    check("x0_no_stall", 160'(load_use_stall), 160'(0));
    cycle();

    // Flush wins over a simultaneous load-use hazard
    apply(lw, 1'b0, 1'b0);  cycle();
    apply(add, 1'b1, 1'b0);
    #1;
    check("flush_prio", 160'({load_use_stall, ifid_flush, pc_write}), 160'(3'b011));
    cycle();
    check("flush_bubble", 160'(idex_valid), 160'(0));

    // Freeze holds everything, even with a flush pending; bubble follows on release
    apply(add, 1'b0, 1'b0);  cycle();
    for (int i = 0; i < 3; i++) begin
      apply(rand_bundle(), 1'b1, 1'b1);
      #1;
      check("freeze_comb", 160'({pc_write, ifid_flush}), 160'(2'b00));
      cycle();
    end
    check("freeze_held", 160'({idex_valid, idex_rs1}), 160'({1'b1, 5'd5}));
    apply(rand_bundle(), 1'b1, 1'b0);  cycle();
    check("release_bubble", 160'(idex_valid), 160'(0));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      apply(rand_bundle(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      cycle();
    end

    // Reset mid-stall clears state at once; no stall after release
    apply(lw, 1'b0, 1'b0);  cycle();
    apply(add, 1'b0, 1'b0);
    #1;
    check("pre_reset_stall", 160'(load_use_stall), 160'(1));
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("midreset_idex", 160'(dut_q), 160'(0));
    check("midreset_comb", 160'({pc_write, ifid_write, ifid_flush, load_use_stall}), 160'(4'b1100));
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("post_reset_loaded", 160'({idex_valid, idex_rs1}), 160'({1'b1, 5'd5}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register with integrated load-use hazard detection and bubble/flush insertion.
- Captures decoded operands and control from the ID stage each cycle.
- Supplies the EX stage, including the idex_rs1/idex_rs2/idex_rd fields consumed by the forwarding logic.
- Drives the PC and IF/ID write enables and the IF/ID flush.

Parameters:
XLEN, 32, datapath width (PC, register data, immediate)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID slot holds a real instruction
id_pc  input  XLEN  PC of ID instruction
id_rs1, id_rs2, id_rd  input  5 each  register indices
id_uses_rs1, id_uses_rs2  input  1 each  instruction actually reads rs1/rs2
id_rs1_data, id_rs2_data, id_imm  input  XLEN each  operands and immediate
id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch  input  1 each  decoded control
id_aluop  input  2  ALU op class
id_funct3  input  3  funct3 field
id_funct7b5  input  1  instr[30]
ex_flush  input  1  taken branch/jump resolved in EX; ID instruction is wrong-path
ext_stall  input  1  global freeze (memory wait)
idex_* outputs  output  matching widths  registered copy of every id_* input above (idex_valid, idex_pc, idex_rs1 ... idex_funct7b5)
pc_write  output  1  PC update enable
ifid_write  output  1  IF/ID register enable
ifid_flush  output  1  clear IF/ID to bubble
load_use_stall  output  1  hazard-inserted bubble this cycle

Behaviour:
- Reset (rst_n=0, async): every idex_* register = 0. Comb outputs then read pc_write=1, ifid_write=1, ifid_flush=0, load_use_stall=0.
- Hazard: lu = idex_valid & idex_memread & (idex_rd!=0) & ((id_uses_rs1 & id_rs1==idex_rd) | (id_uses_rs2 & id_rs2==idex_rd)) & id_valid.
- load_use_stall = lu & ~ex_flush & ~ext_stall (combinational).
- pc_write = ifid_write = ~(ext_stall | load_use_stall).
- ifid_flush = ex_flush & ~ext_stall.
- Register update on rising clk, priority high to low:
  1. ext_stall=1: hold all idex_* (full freeze; flush ignored; EX re-asserts ex_flush after release).
  2. ex_flush=1: load bubble.
  3. load_use_stall=1: load bubble; ID instruction stays in IF/ID and re-evaluates next cycle.
  4. Otherwise: load id_* fields.
- Bubble: every idex_* field = 0, i.e. valid, all control bits, rs1/rs2/rd, data, imm, pc, aluop, funct all zero. rd=0 guarantees the forwarding logic never matches a bubble.
- Latency: one cycle ID->EX. A load-use hazard costs exactly one bubble; the next cycle the load sits in MEM and lu evaluates 0.
- An ID instruction with id_valid=0 loads as given; lu cannot fire on it.
- rs==0 never stalls (idex_rd!=0 term).
- Simultaneous flush + hazard: flush wins; load_use_stall=0 and PC updates to the branch target.
- Reset mid-stall: all state cleared immediately; no stall persists after rst_n rises.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs bubble_cnt and flush_cnt, 32 bits each, reset to 0.
  - bubble_cnt increments on each clk edge where load_use_stall=1.
  - flush_cnt increments on each edge where ifid_flush=1.
  - Both saturate at 0xFFFFFFFF and do not increment while ext_stall=1.
- Not defined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with idex_valid=1 -> all idex_* =0 asynchronously; pc_write=1, ifid_write=1.
- Load-use: EX holds lw x5 (memread=1, rd=5); ID add x6,x5,x7 (uses_rs1=1, rs1=5) -> load_use_stall=1, pc_write=0, next cycle idex_valid=0 and idex_rd=0; following cycle the add loads with idex_rs1=5.
- No false stall: EX lw rd=5; ID lui x6 (uses_rs1=0, rs1 field=5) -> load_use_stall=0 and the lui loads next cycle. Repeat with lw rd=0 -> no stall.
- Flush priority: ex_flush=1 together with a load-use hazard -> load_use_stall=0, ifid_flush=1, pc_write=1, bubble loaded.
- Freeze: ext_stall=1 for 3 cycles with ex_flush=1 and id_* changing -> idex_* unchanged, pc_write=0, ifid_flush=0. On release with ex_flush=1 -> bubble.
- HAZARD_PERF_CNT_EN: 4 load-use stalls and 2 flushes -> bubble_cnt=4, flush_cnt=2. Preload bubble_cnt to 0xFFFFFFFF then stall -> stays 0xFFFFFFFF.
